// File: rtl/lap_stopwatch_core.sv
// BCD stopwatch/timer core: up or count-down timing on a 10 ms tick, clamped preset
// load, and a show-ahead lap FIFO with sticky overflow.
module lap_stopwatch_core #(
    parameter int MIN_DIGITS = 1,
    parameter int LAP_DEPTH  = 8,
    parameter int LAP_AW     = 3
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_tick,
    input  logic                          i_start_stop,
    input  logic                          i_clear,
    input  logic                          i_mode,
    input  logic                          i_load,
    input  logic [16+4*MIN_DIGITS-1:0]    i_preset,
    input  logic                          i_lap,
    input  logic                          i_lap_ready,
    output logic [16+4*MIN_DIGITS-1:0]    o_time_out,
    output logic                          o_running,
    output logic                          o_expired,
    output logic                          o_rollover,
    output logic                          o_lap_valid,
    output logic [16+4*MIN_DIGITS-1:0]    o_lap_data,
    output logic [LAP_AW:0]               o_lap_count,
    output logic                          o_lap_overflow,
    output logic [1:0]                    o_state
);
    localparam int TW = 16 + 4 * MIN_DIGITS;
    localparam int ND = TW / 4;

    // Handshake: a lap entry transfers on any rising edge where o_lap_valid && i_lap_ready;
    // o_lap_data is the FIFO head and stays stable until that transfer happens.

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_time;
    logic          r_mode;
    logic          r_rollover;

    logic [TW-1:0] w_inc;
    logic [TW-1:0] w_dec;
    logic [TW-1:0] w_clamped;
    logic          w_carry;
    logic          w_borrow;

    function automatic logic [3:0] digit_max(input int d);
        return (d == 3) ? 4'd5 : 4'd9;
    endfunction

    // Carry and borrow ripple through every digit in one cycle; w_carry left set means wrap.
    always_comb begin
        w_inc     = r_time;
        w_dec     = r_time;
        w_clamped = i_preset;
        w_carry   = 1'b1;
        w_borrow  = 1'b1;
        for (int d = 0; d < ND; d++) begin
            if (w_carry) begin
                if (r_time[4*d +: 4] >= digit_max(d)) begin
                    w_inc[4*d +: 4] = 4'd0;
                end else begin
                    w_inc[4*d +: 4] = r_time[4*d +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
            if (w_borrow) begin
                if (r_time[4*d +: 4] == 4'd0) begin
                    w_dec[4*d +: 4] = digit_max(d);
                end else begin
                    w_dec[4*d +: 4] = r_time[4*d +: 4] - 4'd1;
                    w_borrow        = 1'b0;
                end
            end
            if (i_preset[4*d +: 4] > digit_max(d)) begin
                w_clamped[4*d +: 4] = digit_max(d);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= ST_STOPPED;
            r_time     <= '0;
            r_mode     <= 1'b0;
            r_rollover <= 1'b0;
        end else begin
            r_rollover <= 1'b0;
            if (i_clear) begin
                r_state <= ST_STOPPED;
                r_time  <= '0;
            end else if (i_load && (r_state != ST_RUN)) begin
                r_state <= ST_STOPPED;
                r_time  <= w_clamped;
            end else begin
                case (r_state)
                    ST_STOPPED: begin
                        // A countdown cannot be started from zero; the mode checked is
                        // the one this start would latch.
                        if (i_start_stop && !(i_mode && (r_time == '0))) begin
                            r_state <= ST_RUN;
                            r_mode  <= i_mode;
                        end
                    end
                    ST_RUN: begin
                        if (i_start_stop) begin
                            r_state <= ST_STOPPED;
                        end
                        if (i_tick) begin
                            if (!r_mode) begin
                                r_time     <= w_inc;
                                r_rollover <= w_carry;
                            end else if ((w_dec == '0) || (r_time == '0)) begin
                                r_time  <= '0;
                                r_state <= ST_EXPIRED;
                            end else begin
                                r_time <= w_dec;
                            end
                        end
                    end
                    ST_EXPIRED: begin
                        r_state <= ST_EXPIRED;
                    end
                    default: begin
                        r_state <= ST_STOPPED;
                    end
                endcase
            end
        end
    end

    logic [TW-1:0]     r_mem [LAP_DEPTH];
    logic [LAP_AW-1:0] r_wr_ptr;
    logic [LAP_AW-1:0] r_rd_ptr;
    logic [LAP_AW:0]   r_count;
    logic              r_overflow;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == (LAP_AW+1)'(LAP_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && i_lap_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push  = i_lap && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset && !i_clear && w_push) begin
            r_mem[r_wr_ptr] <= r_time;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LAP_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LAP_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (LAP_AW+1)'(1);
                2'b01:   r_count <= r_count - (LAP_AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (i_lap && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_time_out     = r_time;
    assign o_running      = (r_state == ST_RUN);
    assign o_expired      = (r_state == ST_EXPIRED);
    assign o_rollover     = r_rollover;
    assign o_lap_valid    = !w_empty;
    assign o_lap_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_lap_count    = r_count;
    assign o_lap_overflow = r_overflow;
    assign o_state        = r_state;
endmodule

// File: tb/tb_lap_stopwatch_core.sv
// Bench for lap_stopwatch_core: vector table, directed corner sequences, then random
// stimulus against a centisecond-count model with a lap queue.
module tb_lap_stopwatch_core;
    localparam int MIN_DIGITS = 1;
    localparam int LAP_DEPTH  = 4;
    localparam int LAP_AW     = 2;
    localparam int TW         = 16 + 4 * MIN_DIGITS;
    localparam int MAX_CS     = (10 ** MIN_DIGITS) * 6000 - 1;
    localparam int M_STOP = 0, M_RUN = 1, M_EXP = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tick = 1'b0, start_stop = 1'b0, clear = 1'b0, mode = 1'b0;
    logic          load = 1'b0, lap = 1'b0, lap_ready = 1'b0;
    logic [TW-1:0] preset = '0;
    logic [TW-1:0] time_out, lap_data;
    logic          running, expired, rollover, lap_valid, lap_overflow;
    logic [LAP_AW:0] lap_count;
    logic [1:0]    state_dbg;

    lap_stopwatch_core #(.MIN_DIGITS(MIN_DIGITS), .LAP_DEPTH(LAP_DEPTH), .LAP_AW(LAP_AW)) dut (
        .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_start_stop(start_stop),
        .i_clear(clear), .i_mode(mode), .i_load(load), .i_preset(preset),
        .i_lap(lap), .i_lap_ready(lap_ready), .o_time_out(time_out),
        .o_running(running), .o_expired(expired), .o_rollover(rollover),
        .o_lap_valid(lap_valid), .o_lap_data(lap_data), .o_lap_count(lap_count),
        .o_lap_overflow(lap_overflow), .o_state(state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [TW-1:0] exp_q[$];

    int m_state, m_time, m_mode, m_ovf, m_roll;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ss, input logic clr, input logic md, input logic ld,
                         input logic [TW-1:0] pre, input logic tk, input logic lp);
        start_stop = ss; clear = clr; mode = md; load = ld; preset = pre; tick = tk; lap = lp;
        cycle();
        start_stop = 0; clear = 0; load = 0; tick = 0; lap = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        m_state = M_STOP; m_time = 0; m_mode = 0; m_ovf = 0; m_roll = 0;
        exp_q.delete();
    endtask

    function automatic logic [TW-1:0] cs2bcd(input int cs);
        logic [TW-1:0] b;
        int mins;
        b = '0;
        b[3:0]   = 4'(cs % 10);
        b[7:4]   = 4'((cs / 10) % 10);
        b[11:8]  = 4'((cs / 100) % 10);
        b[15:12] = 4'((cs / 1000) % 6);
        mins = cs / 6000;
        for (int d = 0; d < MIN_DIGITS; d++) begin
            b[16 + 4*d +: 4] = 4'(mins % 10);
            mins = mins / 10;
        end
        return b;
    endfunction

    function automatic int clampd(input logic [3:0] v, input int lim);
        return (int'(v) > lim) ? lim : int'(v);
    endfunction

    function automatic int preset2cs(input logic [TW-1:0] p);
        int mins, w;
        mins = 0; w = 1;
        for (int d = 0; d < MIN_DIGITS; d++) begin
            mins += w * clampd(p[16 + 4*d +: 4], 9);
            w *= 10;
        end
        return clampd(p[3:0], 9) + 10 * clampd(p[7:4], 9) + 100 * clampd(p[11:8], 9)
             + 1000 * clampd(p[15:12], 5) + 6000 * mins;
    endfunction

    // Next-state model in whole centiseconds; lap queue doubles as the scoreboard.
    task automatic model_step(input logic ss, input logic clr, input logic md, input logic ld,
                              input logic [TW-1:0] pre, input logic tk, input logic lp,
                              input logic rdy);
        int sz;
        bit pop;
        logic [TW-1:0] snap;
        m_roll = 0;
        if (clr) begin
            m_time = 0; m_state = M_STOP; m_ovf = 0;
            exp_q.delete();
            return;
        end
        snap = cs2bcd(m_time);
        sz   = exp_q.size();
        pop  = (sz != 0) && rdy;
        if (pop) void'(exp_q.pop_front());
        if (lp) begin
            if (sz == LAP_DEPTH && !pop) m_ovf = 1;
            else exp_q.push_back(snap);
        end
        if (ld && m_state != M_RUN) begin
            m_time = preset2cs(pre); m_state = M_STOP;
        end else if (m_state == M_STOP) begin
            if (ss && !(md && m_time == 0)) begin m_state = M_RUN; m_mode = md; end
        end else if (m_state == M_RUN) begin
            if (ss) m_state = M_STOP;
            if (tk) begin
                if (m_mode == 0) begin
                    if (m_time == MAX_CS) begin m_time = 0; m_roll = 1; end
                    else m_time = m_time + 1;
                end else if (m_time <= 1) begin
                    m_time = 0; m_state = M_EXP;
                end else begin
                    m_time = m_time - 1;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_time"}, 32'(time_out), 32'(cs2bcd(m_time)));
        check({tag, "_running"}, 32'(running), 32'(m_state == M_RUN));
        check({tag, "_expired"}, 32'(expired), 32'(m_state == M_EXP));
        check({tag, "_rollover"}, 32'(rollover), 32'(m_roll));
        check({tag, "_lap_valid"}, 32'(lap_valid), 32'(exp_q.size() != 0));
        check({tag, "_lap_count"}, 32'(lap_count), 32'(exp_q.size()));
        check({tag, "_lap_data"}, 32'(lap_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
        check({tag, "_overflow"}, 32'(lap_overflow), 32'(m_ovf));
    endtask

    typedef struct {
        logic ss, clr, md, ld;
        logic [TW-1:0] pre;
        logic tk;
        logic [TW-1:0] e_time;
        logic e_run, e_exp;
    } vec_t;

    function automatic vec_t mk(input logic ss, input logic clr, input logic md, input logic ld,
                                input logic [TW-1:0] pre, input logic tk,
                                input logic [TW-1:0] et, input logic er, input logic ee);
        vec_t v;
        v.ss = ss; v.clr = clr; v.md = md; v.ld = ld; v.pre = pre; v.tk = tk;
        v.e_time = et; v.e_run = er; v.e_exp = ee;
        return v;
    endfunction

    vec_t vecs[18];

    initial begin
        vecs[0]  = mk(0, 0, 0, 0, 20'h00000, 0, 20'h00000, 0, 0);
        vecs[1]  = mk(0, 0, 0, 1, 20'h0F0AB, 0, 20'h05099, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 20'h00000, 0, 20'h05099, 1, 0);
        vecs[3]  = mk(0, 0, 0, 0, 20'h00000, 1, 20'h05100, 1, 0);
        vecs[4]  = mk(0, 0, 0, 1, 20'h12345, 1, 20'h05101, 1, 0);
        vecs[5]  = mk(1, 0, 0, 0, 20'h00000, 1, 20'h05102, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 20'h00000, 1, 20'h05102, 0, 0);
        vecs[7]  = mk(1, 0, 0, 0, 20'h00000, 1, 20'h05102, 1, 0);
        vecs[8]  = mk(1, 1, 0, 1, 20'h12345, 0, 20'h00000, 0, 0);
        vecs[9]  = mk(1, 0, 1, 0, 20'h00000, 0, 20'h00000, 0, 0);
        vecs[10] = mk(0, 0, 1, 1, 20'h00002, 0, 20'h00002, 0, 0);
        vecs[11] = mk(1, 0, 1, 0, 20'h00000, 0, 20'h00002, 1, 0);
        vecs[12] = mk(0, 0, 0, 0, 20'h00000, 1, 20'h00001, 1, 0);
        vecs[13] = mk(0, 0, 0, 0, 20'h00000, 1, 20'h00000, 0, 1);
        vecs[14] = mk(1, 0, 0, 0, 20'h00000, 0, 20'h00000, 0, 1);
        vecs[15] = mk(0, 0, 0, 1, 20'h00100, 0, 20'h00100, 0, 0);
        vecs[16] = mk(1, 0, 0, 0, 20'h00000, 0, 20'h00100, 1, 0);
        vecs[17] = mk(0, 0, 0, 0, 20'h00000, 1, 20'h00101, 1, 0);

        do_reset();
        compare_all("reset");
        check("reset_state", 32'(state_dbg), 32'd0);

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].ss, vecs[i].clr, vecs[i].md, vecs[i].ld, vecs[i].pre, vecs[i].tk, 0);
            check($sformatf("vec%0d_time", i), 32'(time_out), 32'(vecs[i].e_time));
            check($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].e_run));
            check($sformatf("vec%0d_expired", i), 32'(expired), 32'(vecs[i].e_exp));
        end

        // Up count through a minute boundary
        drive(0, 1, 0, 0, '0, 0, 0);
        drive(1, 0, 0, 0, '0, 0, 0);
        tick = 1;
        for (int i = 0; i < 100; i++) cycle();
        check("t1_100_ticks", 32'(time_out), 32'h00100);
        for (int i = 0; i < 5900; i++) cycle();
        tick = 0;
        check("t1_6000_ticks", 32'(time_out), 32'h10000);
        check("t1_running", 32'(running), 32'd1);

        // Wrap from the all-max value
        drive(1, 0, 0, 0, '0, 0, 0);
        drive(0, 0, 0, 1, 20'h95999, 0, 0);
        drive(1, 0, 0, 0, '0, 0, 0);
        drive(0, 0, 0, 0, '0, 1, 0);
        check("t2_wrap_time", 32'(time_out), 32'h00000);
        check("t2_rollover_hi", 32'(rollover), 32'd1);
        check("t2_running", 32'(running), 32'd1);
        cycle();
        check("t2_rollover_lo", 32'(rollover), 32'd0);

        // Countdown to expiry
        drive(1, 0, 0, 0, '0, 0, 0);
        drive(0, 0, 1, 1, 20'h00003, 0, 0);
        drive(1, 0, 1, 0, '0, 0, 0);
        drive(0, 0, 1, 0, '0, 1, 0);
        drive(0, 0, 1, 0, '0, 1, 0);
        check("t3_one_left", 32'(time_out), 32'h00001);
        drive(0, 0, 1, 0, '0, 1, 0);
        check("t3_time", 32'(time_out), 32'h00000);
        check("t3_expired", 32'(expired), 32'd1);
        check("t3_running", 32'(running), 32'd0);
        drive(1, 0, 1, 0, '0, 0, 0);
        check("t3_ss_ignored", 32'(expired), 32'd1);
        drive(0, 1, 0, 0, '0, 0, 0);
        check("t3_clear_expired", 32'(expired), 32'd0);

        // Lap FIFO overflow and in-order drain
        exp_q.delete();
        lap_ready = 0;
        drive(1, 0, 0, 0, '0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, '0, 1, 0);
            drive(0, 0, 0, 0, '0, 0, 1);
            if (k < 4) exp_q.push_back(cs2bcd(k + 1));
        end
        check("t4_count", 32'(lap_count), 32'd4);
        check("t4_overflow", 32'(lap_overflow), 32'd1);
        lap_ready = 1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t4_drain%0d", k), 32'(lap_data), 32'(exp_q.pop_front()));
            cycle();
        end
        lap_ready = 0;
        check("t4_valid_after", 32'(lap_valid), 32'd0);
        check("t4_count_after", 32'(lap_count), 32'd0);
        check("t4_overflow_sticky", 32'(lap_overflow), 32'd1);

        // Reset in the middle of a run with laps queued
        drive(0, 1, 0, 0, '0, 0, 0);
        drive(1, 0, 0, 0, '0, 0, 0);
        drive(0, 0, 0, 0, '0, 1, 0);
        drive(0, 0, 0, 0, '0, 0, 1);
        drive(0, 0, 0, 0, '0, 1, 0);
        drive(0, 0, 0, 0, '0, 0, 1);
        check("t6_count_before", 32'(lap_count), 32'd2);
        do_reset();
        compare_all("t6");

        // Random stimulus against the model
        for (int c = 0; c < 4000; c++) begin
            start_stop = ($urandom_range(0, 15) == 0);
            clear      = ($urandom_range(0, 63) == 0);
            load       = ($urandom_range(0, 31) == 0);
            tick       = $urandom_range(0, 1);
            lap        = ($urandom_range(0, 5) == 0);
            lap_ready  = ($urandom_range(0, 2) == 0);
            mode       = $urandom_range(0, 1);
            preset     = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 6)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15))};
            if ($urandom_range(0, 3) == 0) preset = 20'h95990;
            model_step(start_stop, clear, mode, load, preset, tick, lap, lap_ready);
            cycle();
            compare_all("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
